// File: rtl/roll_grid_pkg.sv
// Shared types and helpers for the paper-roll grid eraser.
package roll_grid_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] wide_row_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SWEEP,
    CHECK,
    DONE
  } state_t;

  function automatic logic [6:0] popcount(input wide_row_t v);
    logic [6:0] n;
    wide_row_t  s;
    n = '0;
    s = v;
    for (int i = 0; i < MAX_W; i++) begin
      n = n + 7'(s[0]);
      s = s >> 1;
    end
    return n;
  endfunction

  // Shift the column's 3-cell window down to bits [2:0]; column -1 reads as 0.
  function automatic wide_row_t win(input wide_row_t r, input logic [5:0] col);
    return (col == 6'd0) ? (r << 1) : (r >> (col - 6'd1));
  endfunction

  function automatic logic [3:0] neigh_count(
    input wide_row_t  a,
    input wide_row_t  c,
    input wide_row_t  b,
    input logic [5:0] col
  );
    wide_row_t wa, wc, wb;
    wa = win(a, col);
    wc = win(c, col);
    wb = win(b, col);
    return 4'(wa[0]) + 4'(wa[1]) + 4'(wa[2])
         + 4'(wc[0]) + 4'(wc[2])
         + 4'(wb[0]) + 4'(wb[1]) + 4'(wb[2]);
  endfunction

endpackage

// File: rtl/roll_grid_eraser_mask.sv
// Combinational removal mask for one grid row.
// Rows are zero-extended, so off-grid neighbours read as empty.
module roll_row_mask
  import roll_grid_pkg::*;
#(
  parameter int WIDTH  = 10,
  parameter int THRESH = 4,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] above,
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] below,
  output logic [WIDTH-1:0] mask,
  output logic [CW-1:0]    cnt
);

  wide_row_t a, c, b;

  assign a = wide_row_t'(above);
  assign c = wide_row_t'(cur);
  assign b = wide_row_t'(below);

  for (genvar i = 0; i < WIDTH; i++) begin : g_col
    assign mask[i] = cur[i] &&
      (neigh_count(a, c, b, 6'(i)) < 4'(THRESH));
  end

  assign cnt = CW'(popcount(wide_row_t'(mask)));

endmodule

// File: rtl/roll_grid_eraser.sv
// Roll-removal engine: loads a grid row by row, then sweeps it
// once or until no roll is removable.
module roll_grid_eraser
  import roll_grid_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int DEPTH      = 10,
  parameter int THRESH     = 4,
  parameter int MAX_PASSES = 1023,
  localparam int PASS_W    = $clog2(MAX_PASSES + 1),
  localparam int CNT_W     = $clog2(WIDTH * DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              row_valid,
  output logic              row_ready,
  input  logic [WIDTH-1:0]  row_data,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  total_removed,
  output logic [PASS_W-1:0] passes,
  output logic              capped
);

  localparam int RW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int MW = $clog2(WIDTH + 1);

  state_t state, nxt;

  logic [WIDTH-1:0] grid [DEPTH];
  logic [WIDTH-1:0] prev;
  logic [RW-1:0]    idx, below_idx;
  logic             mode_q;
  logic [CNT_W-1:0] sweep_cnt;

  logic [WIDTH-1:0] cur, above, below, mask;
  logic [MW-1:0]    mask_cnt;
  logic             last_row, at_cap, final_pass;

  assign last_row  = (idx == RW'(DEPTH - 1));
  assign below_idx = last_row ? idx : idx + RW'(1);
  assign cur       = grid[idx];
  assign above     = (idx == '0) ? '0 : prev;
  assign below     = last_row ? '0 : grid[below_idx];

  assign at_cap     = (passes == PASS_W'(MAX_PASSES - 1));
  assign final_pass = !mode_q || (sweep_cnt == '0) || at_cap;

  roll_row_mask #(
    .WIDTH  (WIDTH),
    .THRESH (THRESH)
  ) u_mask (
    .above (above),
    .cur   (cur),
    .below (below),
    .mask  (mask),
    .cnt   (mask_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE, DONE: if (start) nxt = LOAD;
      LOAD:       if (row_valid && last_row) nxt = SWEEP;
      SWEEP:      if (last_row) nxt = CHECK;
      CHECK:      nxt = final_pass ? DONE : SWEEP;
      default:    nxt = IDLE;
    endcase
  end

  always_comb begin
    row_ready = (state == LOAD);
    busy      = (state == LOAD) || (state == SWEEP) ||
                (state == CHECK);
    done      = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grid          <= '{default: '0};
      prev          <= '0;
      idx           <= '0;
      mode_q        <= 1'b0;
      sweep_cnt     <= '0;
      total_removed <= '0;
      passes        <= '0;
      capped        <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: if (start) begin
          mode_q        <= mode;
          idx           <= '0;
          sweep_cnt     <= '0;
          total_removed <= '0;
          passes        <= '0;
          capped        <= 1'b0;
        end
        LOAD: if (row_valid) begin
          grid[idx] <= row_data;
          idx       <= last_row ? '0 : idx + RW'(1);
        end
        SWEEP: begin
          grid[idx] <= cur & ~mask;
          prev      <= cur;
          sweep_cnt <= sweep_cnt + CNT_W'(mask_cnt);
          idx       <= last_row ? '0 : idx + RW'(1);
        end
        CHECK: begin
          total_removed <= total_removed + sweep_cnt;
          passes        <= passes + PASS_W'(1);
          if (mode_q && at_cap && sweep_cnt != '0) capped <= 1'b1;
          if (!final_pass) sweep_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_roll_grid_eraser.sv
// Scoreboard bench: driver queues expected results, a monitor
// pops and compares on each rising done.
module tb_roll_grid_eraser;

  typedef struct {
    int tot;
    int ps;
    int cap;
    int lat;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       start_b = 1'b0;
  logic       mode = 1'b0;
  logic       row_valid = 1'b0;
  logic [9:0] row_data = '0;

  logic       rdy_a, busy_a, done_a, cap_a;
  logic [6:0] tot_a;
  logic [9:0] ps_a;
  logic       rdy_b, busy_b, done_b, cap_b;
  logic [6:0] tot_b;
  logic [1:0] ps_b;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  exp_t qa[$];
  exp_t qb[$];

  logic [9:0] ex [10] = '{
    10'b0011011110, 10'b1110101011, 10'b1111101011,
    10'b1011110010, 10'b1101111011, 10'b0111111101,
    10'b0101010111, 10'b1011101111, 10'b0111111110,
    10'b1010111010
  };

  roll_grid_eraser dut_a (
    .clk (clk), .rst (rst), .start (start), .mode (mode),
    .row_valid (row_valid), .row_ready (rdy_a),
    .row_data (row_data), .busy (busy_a), .done (done_a),
    .total_removed (tot_a), .passes (ps_a), .capped (cap_a)
  );

  roll_grid_eraser #(.MAX_PASSES(2)) dut_b (
    .clk (clk), .rst (rst), .start (start_b), .mode (mode),
    .row_valid (row_valid), .row_ready (rdy_b),
    .row_data (row_data), .busy (busy_b), .done (done_b),
    .total_removed (tot_b), .passes (ps_b), .capped (cap_b)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input int act, input int want);
    n_total++;
    if (act != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  function automatic logic [9:0] row_of(input int gid, input int r);
    if (gid == 0) return ex[r];
    if (gid == 1) return 10'h3ff;
    return 10'h000;
  endfunction

  // Plain array simulation of simultaneous removal sweeps.
  function automatic void model(input int gid, input bit md,
                                input int maxp, output int tot,
                                output int ps, output int cap);
    bit g [10][10];
    bit ng [10][10];
    int cnt, n, rr, cc;
    logic [9:0] rw;
    for (int r = 0; r < 10; r++) begin
      rw = row_of(gid, r);
      for (int c = 0; c < 10; c++) g[r][c] = rw[c];
    end
    tot = 0; ps = 0; cap = 0;
    while (1) begin
      cnt = 0;
      ng = g;
      for (int r = 0; r < 10; r++)
        for (int c = 0; c < 10; c++)
          if (g[r][c]) begin
            n = 0;
            for (int dr = -1; dr <= 1; dr++)
              for (int dc = -1; dc <= 1; dc++) begin
                rr = r + dr; cc = c + dc;
                if (!(dr == 0 && dc == 0) && rr >= 0 && rr < 10 &&
                    cc >= 0 && cc < 10 && g[rr][cc]) n++;
              end
            if (n < 4) begin ng[r][c] = 1'b0; cnt++; end
          end
      g = ng;
      tot += cnt;
      ps++;
      if (!md || cnt == 0 || ps == maxp) begin
        cap = (md && cnt != 0 && ps == maxp) ? 1 : 0;
        break;
      end
    end
  endfunction

  // Monitor: sample at negedge, away from the active edge.
  initial begin
    int acc_a = 0, acc_b = 0;
    logic dd_a = 1'b0, dd_b = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rdy_a && row_valid) acc_a = cyc;
      if (rdy_b && row_valid) acc_b = cyc;
      if (done_a && !dd_a) begin
        if (qa.size() == 0) check("a_unexpected_done", 1, 0);
        else begin
          e = qa.pop_front();
          check("a_total", int'(tot_a), e.tot);
          check("a_passes", int'(ps_a), e.ps);
          check("a_capped", int'(cap_a), e.cap);
          check("a_latency", cyc - acc_a - 1, e.lat);
        end
      end
      if (done_b && !dd_b) begin
        if (qb.size() == 0) check("b_unexpected_done", 1, 0);
        else begin
          e = qb.pop_front();
          check("b_total", int'(tot_b), e.tot);
          check("b_passes", int'(ps_b), e.ps);
          check("b_capped", int'(cap_b), e.cap);
          check("b_latency", cyc - acc_b - 1, e.lat);
        end
      end
      dd_a = done_a;
      dd_b = done_b;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input bit to_b, input int gid, input bit md,
                      input int gap, input bit poke);
    bit rdy;
    int guard;
    tick();
    mode = md;
    if (to_b) start_b = 1'b1;
    else      start   = 1'b1;
    tick();
    start = 1'b0;
    start_b = 1'b0;
    for (int r = 0; r < 10; r++) begin
      row_valid = 1'b1;
      row_data  = row_of(gid, r);
      guard = 0;
      rdy = 1'b0;
      while (!rdy && guard < 50) begin
        rdy = to_b ? rdy_b : rdy_a;
        tick();
        guard++;
      end
      if (!rdy) check("load_ready_timeout", 0, 1);
      row_valid = 1'b0;
      repeat (gap) tick();
    end
    if (poke) begin
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
    end
  endtask

  task automatic wait_drain(input bit to_b);
    int guard = 0;
    while ((to_b ? qb.size() : qa.size()) != 0 && guard < 3000) begin
      tick();
      guard++;
    end
    if (guard >= 3000) begin
      check("done_timeout", 0, 1);
      qa.delete();
      qb.delete();
    end
  endtask

  task automatic push_a(input int t, input int p, input int c);
    exp_t e;
    e.tot = t; e.ps = p; e.cap = c; e.lat = p * 11;
    qa.push_back(e);
  endtask

  initial begin
    int mt, mp, mc;
    exp_t e;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_ready", int'(rdy_a), 0);
    check("rst_busy", int'(busy_a), 0);
    check("rst_done", int'(done_a), 0);
    check("rst_total", int'(tot_a), 0);
    check("rst_passes", int'(ps_a), 0);
    check("rst_capped", int'(cap_a), 0);

    push_a(13, 1, 0);
    load(1'b0, 0, 1'b0, 0, 1'b0);
    wait_drain(1'b0);
    tick();
    check("done_hold", int'(done_a), 1);
    check("done_not_busy", int'(busy_a), 0);

    push_a(43, 10, 0);
    load(1'b0, 0, 1'b1, 0, 1'b0);
    wait_drain(1'b0);

    model(1, 1'b1, 1023, mt, mp, mc);
    push_a(mt, mp, mc);
    load(1'b0, 1, 1'b1, 0, 1'b0);
    wait_drain(1'b0);

    push_a(0, 1, 0);
    load(1'b0, 2, 1'b0, 0, 1'b0);
    wait_drain(1'b0);
    push_a(0, 1, 0);
    load(1'b0, 2, 1'b1, 0, 1'b0);
    wait_drain(1'b0);

    push_a(43, 10, 0);
    load(1'b0, 0, 1'b1, 1, 1'b0);
    wait_drain(1'b0);

    e.tot = 25; e.ps = 2; e.cap = 1; e.lat = 22;
    qb.push_back(e);
    load(1'b1, 0, 1'b1, 0, 1'b0);
    wait_drain(1'b1);

    load(1'b0, 0, 1'b1, 0, 1'b0);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", int'(busy_a), 0);
    check("abort_done", int'(done_a), 0);
    check("abort_ready", int'(rdy_a), 0);
    check("abort_total", int'(tot_a), 0);
    check("abort_passes", int'(ps_a), 0);
    check("abort_capped", int'(cap_a), 0);
    check("abort_b_total", int'(tot_b), 0);

    push_a(43, 10, 0);
    load(1'b0, 0, 1'b1, 0, 1'b1);
    wait_drain(1'b0);

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
